lsu_mem_initiator: RTL and testbench

Load/store unit that initiates all data-side accesses to the word-organised, single-cycle-read-latency block RAM controller. It accepts one RV32I load or store per handshake from the execute stage and performs byte-lane extraction with sign/zero extension for loads. Sub-word stores use read-modify-write. It stalls the pipeline while busy and flags misaligned accesses. It sits between the execute/memory pipeline stage and the RAM controller's load/store ports.

---
 rtl/lsu_mem_initiator.sv | 193 +++++++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_initiator.sv
// Load/store unit driving a word-organised, single-cycle-read-latency block RAM.
// Optional misaligned-access trap built when LSU_MISALIGN_TRAP_EN is defined.
module lsu_mem_initiator (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        stall,
    output logic        trap_misaligned,
    output logic [31:0] trap_addr,
    output logic [31:0] mem_load_address,
    input  logic [31:0] mem_load_value,
    output logic [31:0] mem_store_address,
    output logic        mem_store_enabled,
    output logic [31:0] mem_store_value
);

    typedef enum logic [2:0] {
        StIdle,
        StLdAddr,
        StLdData,
        StStWord,
        StRmwAddr,
        StRmwWrite
`ifdef LSU_MISALIGN_TRAP_EN
        , StTrap
`endif
    } state_e;

    state_e      r_state, w_state_next;
    logic [31:0] r_addr;
    logic [2:0]  r_funct3;
    logic        r_store;
    logic [31:0] r_wdata;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;

    logic        w_req_byte, w_req_half, w_req_word;
    logic        w_q_byte, w_q_half;
    logic [31:0] w_addr_in;
    logic [7:0]  w_lane_byte;
    logic [15:0] w_lane_half;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;
    logic        w_accept;

    // funct3 values 3/6/7 are never issued and fall through to word size.
    assign w_req_byte = (req_funct3 == 3'd0) || (req_funct3 == 3'd4);
    assign w_req_half = (req_funct3 == 3'd1) || (req_funct3 == 3'd5);
    assign w_req_word = !w_req_byte && !w_req_half;
    assign w_q_byte   = (r_funct3 == 3'd0) || (r_funct3 == 3'd4);
    assign w_q_half   = (r_funct3 == 3'd1) || (r_funct3 == 3'd5);

    assign w_accept = req_valid && (r_state == StIdle);

`ifdef LSU_MISALIGN_TRAP_EN
    logic        w_misaligned;
    logic        r_trap;
    logic [31:0] r_trap_addr;

    assign w_misaligned = (w_req_half && req_addr[0]) ||
                          (w_req_word && (req_addr[1:0] != 2'b00));
    assign w_addr_in    = req_addr;
`else
    // Without the trap, offset bits below natural alignment are dropped.
    always_comb begin
        w_addr_in = req_addr;
        if (w_req_half) w_addr_in[0] = 1'b0;
        if (w_req_word) w_addr_in[1:0] = 2'b00;
    end
`endif

    always_comb begin
        w_lane_byte = mem_load_value[7:0];
        case (r_addr[1:0])
            2'd0: w_lane_byte = mem_load_value[7:0];
            2'd1: w_lane_byte = mem_load_value[15:8];
            2'd2: w_lane_byte = mem_load_value[23:16];
            2'd3: w_lane_byte = mem_load_value[31:24];
            default: w_lane_byte = mem_load_value[7:0];
        endcase
        w_lane_half = r_addr[1] ? mem_load_value[31:16] : mem_load_value[15:0];

        if (w_q_byte) begin
            w_load_data = {{24{!r_funct3[2] && w_lane_byte[7]}}, w_lane_byte};
        end else if (w_q_half) begin
            w_load_data = {{16{!r_funct3[2] && w_lane_half[15]}}, w_lane_half};
        end else begin
            w_load_data = mem_load_value;
        end
    end

    always_comb begin
        w_merged = mem_load_value;
        if (w_q_half) begin
            if (r_addr[1]) w_merged[31:16] = r_wdata[15:0];
            else           w_merged[15:0]  = r_wdata[15:0];
        end else begin
            case (r_addr[1:0])
                2'd0: w_merged[7:0]   = r_wdata[7:0];
                2'd1: w_merged[15:8]  = r_wdata[7:0];
                2'd2: w_merged[23:16] = r_wdata[7:0];
                2'd3: w_merged[31:24] = r_wdata[7:0];
                default: w_merged = mem_load_value;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (req_valid) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    if (w_misaligned)   w_state_next = StTrap;
                    else
`endif
                    if (!req_store)     w_state_next = StLdAddr;
                    else if (w_req_word) w_state_next = StStWord;
                    else                w_state_next = StRmwAddr;
                end
            end
            StLdAddr:   w_state_next = StLdData;
            StLdData:   w_state_next = StIdle;
            StStWord:   w_state_next = StIdle;
            StRmwAddr:  w_state_next = StRmwWrite;
            StRmwWrite: w_state_next = StIdle;
`ifdef LSU_MISALIGN_TRAP_EN
            StTrap:     w_state_next = StIdle;
`endif
            default:    w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_addr       <= 32'd0;
            r_funct3     <= 3'd0;
            r_store      <= 1'b0;
            r_wdata      <= 32'd0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
        end else begin
            r_state      <= w_state_next;
            r_resp_valid <= (r_state == StLdData) || (r_state == StStWord) ||
                            (r_state == StRmwWrite);
            if (r_state == StLdData) r_resp_rdata <= w_load_data;
            if (w_accept) begin
                r_addr   <= w_addr_in;
                r_funct3 <= req_funct3;
                r_store  <= req_store;
                r_wdata  <= req_wdata;
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trap      <= 1'b0;
            r_trap_addr <= 32'd0;
        end else begin
            r_trap <= (r_state == StTrap);
            if (r_state == StTrap) r_trap_addr <= r_addr;
        end
    end
    assign trap_misaligned = r_trap;
    assign trap_addr       = r_trap_addr;
`else
    assign trap_misaligned = 1'b0;
    assign trap_addr       = 32'd0;
`endif

    // Strobe is combinational on state so reset drops a pending write at once.
    assign req_ready         = (r_state == StIdle) && !rst;
    assign stall             = (r_state != StIdle);
    assign resp_valid        = r_resp_valid;
    assign resp_rdata        = r_resp_rdata;
    assign mem_load_address  = {r_addr[31:2], 2'b00};
    assign mem_store_address = {r_addr[31:2], 2'b00};
    assign mem_store_enabled = r_store &&
                               ((r_state == StStWord) || (r_state == StRmwWrite));
    assign mem_store_value   = (r_state == StStWord)   ? r_wdata  :
                               (r_state == StRmwWrite) ? w_merged : 32'd0;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a one-cycle-latency word RAM model.
module tb_lsu_mem_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        stall;
    logic        trap_misaligned;
    logic [31:0] trap_addr;
    logic [31:0] mem_load_address;
    logic [31:0] mem_load_value = 32'd0;
    logic [31:0] mem_store_address;
    logic        mem_store_enabled;
    logic [31:0] mem_store_value;

    int checks = 0;
    int failures = 0;

    bit [31:0]   mem [256];
    bit          mem_loaded = 1'b0;
    int          store_count = 0;
    logic [31:0] last_store_addr = 32'd0;
    logic [31:0] last_store_value = 32'd0;

    always #5 clk = ~clk;

    lsu_mem_initiator dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_store         (req_store),
        .req_funct3        (req_funct3),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .resp_valid        (resp_valid),
        .resp_rdata        (resp_rdata),
        .stall             (stall),
        .trap_misaligned   (trap_misaligned),
        .trap_addr         (trap_addr),
        .mem_load_address  (mem_load_address),
        .mem_load_value    (mem_load_value),
        .mem_store_address (mem_store_address),
        .mem_store_enabled (mem_store_enabled),
        .mem_store_value   (mem_store_value)
    );

    // Word RAM: read data appears one cycle after the address; writes commit on the edge.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            mem[16]    <= 32'h8899AABB;
            mem_loaded <= 1'b1;
        end else begin
            mem_load_value <= mem[mem_load_address[9:2]];
            if (mem_store_enabled) begin
                mem[mem_store_address[9:2]] <= mem_store_value;
                store_count      <= store_count + 1;
                last_store_addr  <= mem_store_address;
                last_store_value <= mem_store_value;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Returns just after the accepting edge.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        int waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int cycles);
        cycles = 0;
        while (cycles < 10) begin
            @(posedge clk);
            #1;
            cycles++;
            if (resp_valid) break;
        end
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] exp);
        int lat;
        issue(1'b0, f3, addr, 32'd0);
        wait_resp(lat);
        check({tag, "_lat"}, 32'(lat), 32'd2);
        check({tag, "_data"}, resp_rdata, exp);
    endtask

    initial begin
        int lat;
        int sc0;

        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_store_en", 32'(mem_store_enabled), 32'd0);
        check("rst_load_addr", mem_load_address, 32'd0);
        check("rst_store_val", mem_store_value, 32'd0);
        check("rst_trap", 32'(trap_misaligned), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(req_ready), 32'd1);

        do_load("lb_43", 3'd0, 32'h43, 32'hFFFFFF88);
        do_load("lbu_43", 3'd4, 32'h43, 32'h00000088);
        do_load("lh_42", 3'd1, 32'h42, 32'hFFFF8899);
        do_load("lhu_40", 3'd5, 32'h40, 32'h0000AABB);
        do_load("lw_40", 3'd2, 32'h40, 32'h8899AABB);

        sc0 = store_count;
        issue(1'b1, 3'd0, 32'h41, 32'h000000CC);
        wait_resp(lat);
        check("sb_lat", 32'(lat), 32'd2);
        check("sb_writes", 32'(store_count - sc0), 32'd1);
        check("sb_value", last_store_value, 32'h8899CCBB);
        check("sb_addr", last_store_addr, 32'h40);
        do_load("lw_after_sb", 3'd2, 32'h40, 32'h8899CCBB);

        sc0 = store_count;
        issue(1'b1, 3'd2, 32'h80, 32'h12345678);
        check("sw_stall_on", 32'(stall), 32'd1);
        check("sw_strobe", 32'(mem_store_enabled), 32'd1);
        wait_resp(lat);
        check("sw_lat", 32'(lat), 32'd1);
        check("sw_stall_off", 32'(stall), 32'd0);
        check("sw_writes", 32'(store_count - sc0), 32'd1);
        do_load("lw_after_sw", 3'd2, 32'h80, 32'h12345678);

`ifdef LSU_MISALIGN_TRAP_EN
        sc0 = store_count;
        issue(1'b0, 3'd2, 32'h42, 32'd0);
        @(posedge clk);
        #1;
        check("trap_pulse", 32'(trap_misaligned), 32'd1);
        check("trap_addr", trap_addr, 32'h42);
        check("trap_no_resp", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1;
        check("trap_pulse_end", 32'(trap_misaligned), 32'd0);
        check("trap_no_resp2", 32'(resp_valid), 32'd0);
        check("trap_no_write", 32'(store_count - sc0), 32'd0);
`else
        do_load("lw_42_aligned", 3'd2, 32'h42, 32'h8899CCBB);
        check("no_trap", 32'(trap_misaligned), 32'd0);
`endif

        sc0 = store_count;
        issue(1'b1, 3'd1, 32'h82, 32'h0000BEEF);
        @(posedge clk);
        #1;
        check("sh_in_rmw_write", 32'(mem_store_enabled), 32'd1);
        rst = 1'b1;
        #1;
        check("rstmid_store_en", 32'(mem_store_enabled), 32'd0);
        check("rstmid_stall", 32'(stall), 32'd0);
        check("rstmid_ready", 32'(req_ready), 32'd0);
        check("rstmid_addr", mem_store_address, 32'd0);
        @(posedge clk);
        #1;
        check("rstmid_no_write", 32'(store_count - sc0), 32'd0);
        check("rstmid_mem_kept", mem[32], 32'h12345678);
        check("rstmid_no_resp", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmid_ready_after", 32'(req_ready), 32'd1);
        do_load("lw_after_rst", 3'd2, 32'h80, 32'h12345678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
